leiwand_rv32_mem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the core's valid/ready memory bus. It lets the leiwand_rv32_core (master 0) and a second requester (master 1, e.g. a program loader or DMA) share one simple_mem instance. Arbitration is round-robin with a registered grant held until the slave completes. A timeout watchdog terminates hung transfers and flags a bus error.

---
 rtl/leiwand_rv32_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_leiwand_rv32_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// leiwand_rv32_mem_arbiter
//
// Two-master / one-slave arbiter for the valid/ready memory bus. Master 0 is
// the leiwand_rv32_core, master 1 a second requester (loader, DMA). The grant
// is registered and round-robin on ties. It is held until the slave completes,
// the master aborts, or the timeout watchdog force-terminates the transfer.
// Every completion passes through IDLE for at least one cycle. This gives the
// finishing master time to drop valid before the next arbitration.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   m0_* / m1_*         master ports: valid/addr/wdata/wen in, ready/rdata out
//   s_*                 slave port: valid/addr/wdata/wen out, ready/rdata in
//   grant_id            currently or last granted master
//   bus_error           one-cycle pulse after a timed-out transfer
// -----------------------------------------------------------------------------
module leiwand_rv32_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  input  logic [XLEN/8-1:0] m0_wen,
  output logic [XLEN-1:0]   m0_rdata,

  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  input  logic [XLEN/8-1:0] m1_wen,
  output logic [XLEN-1:0]   m1_rdata,

  output logic              s_valid,
  input  logic              s_ready,
  output logic [XLEN-1:0]   s_addr,
  output logic [XLEN-1:0]   s_wdata,
  output logic [XLEN/8-1:0] s_wen,
  input  logic [XLEN-1:0]   s_rdata,

  output logic              grant_id,
  output logic              bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_error_q, bus_error_d;

  // Signals of the currently granted master
  logic              g_valid;
  logic              g_ready;
  logic [XLEN-1:0]   g_rdata;
  logic              timeout;

  assign g_valid = grant_q ? m1_valid : m0_valid;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge value of every other flop, independent of
  // statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // makes the first tie after reset go to master 0
      cnt_q        <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // NOTE: every output of this block gets a default before the case
  // statement, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    bus_error_d  = 1'b0;

    timeout  = 1'b0;
    g_ready  = 1'b0;
    g_rdata  = '0;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wen    = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = GRANT;
          cnt_d   = '0;
          if (m0_valid && m1_valid) grant_d = ~last_grant_q;
          else                      grant_d = m1_valid;
        end
      end

      GRANT: begin
        // s_ready in the last allowed cycle wins over the watchdog
        timeout = g_valid && !s_ready && (cnt_q == CNT_LAST);

        s_valid = g_valid && !timeout;
        s_addr  = grant_q ? m1_addr  : m0_addr;
        s_wdata = grant_q ? m1_wdata : m0_wdata;
        s_wen   = grant_q ? m1_wen   : m0_wen;

        // A timed-out master is released with a ready carrying zero data
        g_ready = s_ready || timeout;
        g_rdata = timeout ? '0 : s_rdata;
        if (grant_q) begin
          m1_ready = g_ready;
          m1_rdata = g_rdata;
        end else begin
          m0_ready = g_ready;
          m0_rdata = g_rdata;
        end

        // Completion, abort (valid dropped) and timeout all end the grant
        if (s_ready || !g_valid || timeout) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          bus_error_d  = timeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign grant_id  = grant_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
`timescale 1ns/1ps
module tb_leiwand_rv32_mem_arbiter;

  localparam int XLEN = 32;
  localparam int T    = 4;

  logic        clk;
  logic        reset;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wen, m1_wen, s_wen;
  logic        s_valid, s_ready, grant_id, bus_error;
  logic [31:0] s_addr, s_wdata, s_rdata;

  leiwand_rv32_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wen(m0_wen), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wen(m1_wen), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wen(s_wen), .s_rdata(s_rdata),
    .grant_id(grant_id), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected response of one transfer, pushed when the master issues it
  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;    // cycles from issue to ready, -1 = not checked
    int          issue;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
  } slog_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          order_q[$];
  slog_t       slave_log[$];
  logic [31:0] model_mem[16];
  logic [31:0] slv_mem[16];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave decode: word = {addr[16], addr[4:2]}; latency in cycles = addr[10:8]
  function automatic logic [3:0] key_of(input logic [31:0] a);
    return {a[16], a[4:2]};
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    int l;
    l = int'(a[10:8]);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0101_0011;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_m(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] w);
    if (m == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wen = w;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wen = w;
    end
  endtask

  // ---------------------------------------------------------------- slave
  logic s_active = 1'b0;
  int   s_k, s_l;

  task automatic respond();
    logic [3:0] k;
    k       = key_of(s_addr);
    s_ready = 1'b1;
    s_rdata = slv_mem[k];
    for (int b = 0; b < 4; b++)
      if (s_wen[b]) slv_mem[k][b*8 +: 8] = s_wdata[b*8 +: 8];
  endtask

  always begin
    @(negedge clk); #1;
    if (!reset) begin
      s_active = 1'b0;
      s_ready  = 1'b0;
    end else begin
      if (s_ready) begin
        s_ready  = 1'b0;
        s_active = 1'b0;
      end else if (s_active) begin
        s_k++;
        if (s_k == s_l)    respond();
        else if (!s_valid) s_active = 1'b0;
      end
      if (!s_active && !s_ready && s_valid) begin
        s_active = 1'b1;
        s_k      = 1;
        s_l      = lat_of(s_addr);
        slave_log.push_back('{addr: s_addr, wdata: s_wdata, wen: s_wen});
        if (s_l == 1) respond();
      end
    end
  end

  // -------------------------------------------------------------- monitor
  bit err_next  = 1'b0;
  bit prev_done = 1'b0;

  task automatic handle(input int m);
    exp_t        e;
    logic [31:0] rd;
    rd = (m == 0) ? m0_rdata : m1_rdata;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_mis++;
      $display("FAIL ready_m%0d: got unexpected ready, expected none (cycle %0d)", m, cyc);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("rdata_m%0d", m), rd, e.rdata);
    check($sformatf("s_valid_at_ready_m%0d", m), 32'(s_valid), 32'(!e.err));
    if (e.lat >= 0) check($sformatf("latency_m%0d", m), 32'(cyc - e.issue), 32'(e.lat));
    if (e.err) err_next = 1'b1;
    order_q.push_back(m);
    prev_done = 1'b1;
  endtask

  always begin
    @(negedge clk); #2;
    if (!reset) begin
      err_next  = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("bus_error", 32'(bus_error), 32'(err_next));
      err_next = 1'b0;
      if (prev_done) begin
        check("bubble_s_valid", 32'(s_valid), 32'h0);
        check("bubble_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
      end
      prev_done = 1'b0;
      if (m0_ready) handle(0);
      if (m1_ready) handle(1);
    end
  end

  // ------------------------------------------------------- master drivers
  task automatic run_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] w, input bit chk_lat);
    exp_t       e;
    logic [3:0] k;
    bit         got;
    @(negedge clk);
    k       = key_of(a);
    e.err   = lat_of(a) > T;
    e.rdata = e.err ? 32'h0 : model_mem[k];
    if (!e.err)
      for (int b = 0; b < 4; b++)
        if (w[b]) model_mem[k][b*8 +: 8] = d[b*8 +: 8];
    e.lat   = chk_lat ? (e.err ? T : lat_of(a)) : -1;
    e.issue = cyc;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
    set_m(m, 1'b1, a, d, w);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      #3;
      got = (m == 0) ? m0_ready : m1_ready;
      if (!got) @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_mis++;
      $display("FAIL wait_ready_m%0d: got no ready within 100 cycles, expected ready", m);
      set_m(m, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic release_m(input int m);
    @(negedge clk);
    set_m(m, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rand_master(input int m, input int n);
    int          idx, r, lat, g;
    logic [31:0] a;
    logic [3:0]  w;
    for (int i = 0; i < n; i++) begin
      idx = $urandom_range(0, 7);
      r   = $urandom_range(0, 9);
      lat = (r < 8) ? (r % 4) + 1 : r - 3;   // mostly 1..4, sometimes 5/6
      a   = 32'h8000_0000 | (32'(m) << 16) | (32'(lat) << 8) | (32'(idx) << 2);
      w   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(m, a, $urandom, w, 1'b0);
      g = $urandom_range(0, 2);
      if (g > 0) begin
        release_m(m);
        repeat (g - 1) @(negedge clk);
      end
    end
    release_m(m);
  endtask

  task automatic check_order(input string name, input int exp_order[]);
    check({name, "_count"}, 32'(order_q.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < order_q.size(); i++)
      check(name, 32'(order_q[i]), 32'(exp_order[i]));
  endtask

  // ------------------------------------------------------------ main flow
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      model_mem[k] = init_word(k);
      slv_mem[k]   = init_word(k);
    end
    model_mem[1] = 32'h0050_0093;
    slv_mem[1]   = 32'h0050_0093;

    // Reset with both masters requesting: every output must stay zero
    reset   = 1'b0;
    s_ready = 1'b0;
    s_rdata = 32'hFFFF_FFFF;
    set_m(0, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF);
    set_m(1, 1'b1, 32'h8001_0000, 32'h8765_4321, 4'hF);
    repeat (3) @(negedge clk);
    #3;
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_s_wen", 32'(s_wen), 32'h0);
    check("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 reset = 1'b1;

    // Simultaneous, continuously re-requesting masters: strict alternation
    order_q.delete();
    fork
      repeat (3) run_txn(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0);
      repeat (3) run_txn(1, 32'h8001_0000, 32'h0, 4'h0, 1'b0);
    join
    release_m(0);
    release_m(1);
    check_order("rr_order", '{0, 1, 0, 1, 0, 1});

    // Single master 0 read, one-cycle slave
    run_txn(0, 32'h8000_0004, 32'h0, 4'h0, 1'b1);
    release_m(0);

    // Master 1 byte write; master 0 requests during it and must wait
    order_q.delete();
    slave_log.delete();
    fork
      run_txn(1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 1'b1);
      begin
        @(negedge clk);
        run_txn(0, 32'h8000_0010, 32'h0, 4'h0, 1'b0);
      end
    join
    release_m(0);
    release_m(1);
    check_order("write_order", '{1, 0});
    check("write_log_count", 32'(slave_log.size()), 32'd2);
    if (slave_log.size() > 0) begin
      check("write_s_addr", slave_log[0].addr, 32'h8000_0010);
      check("write_s_wen", 32'(slave_log[0].wen), 32'b0010);
      check("write_s_wdata", slave_log[0].wdata, 32'h0000_AB00);
    end

    // Timeout: 6-cycle slave against a 4-cycle watchdog (write not committed)
    run_txn(0, 32'h8000_0608, 32'hDEAD_BEEF, 4'hF, 1'b1);
    // Slave answers in the last allowed cycle: completes, no error
    run_txn(0, 32'h8000_0408, 32'h0, 4'h0, 1'b1);
    release_m(0);

    // Abort: master 0 drops valid while granted
    @(negedge clk);
    set_m(0, 1'b1, 32'h8000_0600, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #3;
    check("abort_s_valid", 32'(s_valid), 32'h0);
    check("abort_m0_ready", 32'(m0_ready), 32'h0);
    run_txn(0, 32'h8000_0004, 32'h0, 4'h0, 1'b1);
    release_m(0);

    // Reset in the middle of a master 1 grant
    @(negedge clk);
    set_m(1, 1'b1, 32'h8001_0600, 32'h0, 4'h0);
    @(negedge clk);
    #4;
    check("pre_rst_grant_id", 32'(grant_id), 32'h1);
    reset = 1'b0;
    #1;
    check("midrst_s_valid", 32'(s_valid), 32'h0);
    check("midrst_grant_id", 32'(grant_id), 32'h0);
    check("midrst_m1_ready", 32'(m1_ready), 32'h0);
    set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #4 reset = 1'b1;

    // First tie after this reset goes to master 0 again
    order_q.delete();
    fork
      run_txn(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0);
      run_txn(1, 32'h8001_0000, 32'h0, 4'h0, 1'b0);
    join
    release_m(0);
    release_m(1);
    // The master still holding valid re-arbitrates once more before release
    check("post_rst_first", (order_q.size() > 0) ? 32'(order_q[0]) : 32'hFFFF_FFFF, 32'h0);

    // Randomised traffic from both masters
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join

    repeat (5) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
